box_readback: RTL and testbench
===============================

# box_readback

Framebuffer region reader for the 160x120, 3-bit-colour display path. It accepts a rectangle with the same coordinate and inclusive-extent convention the box drawer uses to write pixels. It scans that rectangle in raster order, issuing one read per pixel to the framebuffer's synchronous read port, and counts returned pixels equal to a target colour. The game FSM uses it to confirm a square was painted, or to test a region's contents, before advancing.

## Interface
Parameters:
- X_SCREEN_PIXELS, 160, screen width; also the address row stride.
- Y_SCREEN_PIXELS, 120, screen height.
- RD_LATENCY, 1, framebuffer read latency in cycles; legal range 1..3.

Ports:
- iClock  input  1  sole clock; all logic is rising-edge.
- iReset  input  1  asynchronous, active-high reset.
- iStart  input  1  start request; sampled only in IDLE.
- iX  input  8  top-left x.
- iY  input  7  top-left y.
- iXSize  input  8  inclusive x extent; width is iXSize+1.
- iYSize  input  7  inclusive y extent; height is iYSize+1.
- iColour  input  3  target colour.
- oAddr  output  15  framebuffer read address, y*X_SCREEN_PIXELS + x.
- oRdEn  output  1  read strobe, valid with oAddr.
- iRdData  input  3  framebuffer data, valid RD_LATENCY cycles after oRdEn.
- oBusy  output  1  high in SCAN and DRAIN.
- oDone  output  1  one-cycle completion pulse.
- oPixelCount  output  15  number of in-screen pixels read.
- oMatchCount  output  15  number of read pixels equal to the target colour.
- oAllMatch  output  1  high when oPixelCount != 0 and oMatchCount == oPixelCount.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE -> SCAN on iStart:
  - latch iX, iY, iXSize, iYSize, iColour;
  - clear both counts and oAllMatch;
  - zero the column and row offsets cx and cy.
- SCAN, one pixel per cycle:
  - current pixel is px = X + cx (9-bit sum, no wrap) and py = Y + cy (8-bit sum, no wrap);
  - in-screen pixel (px < 160 and py < 120): register oRdEn = 1 and oAddr = py*160 + px;
  - clipped pixel: oRdEn = 0, oAddr holds its previous value, and the cycle is still consumed.
- Offset advance:
  - cx == XSize: cx <= 0, and cy increments;
  - otherwise cx increments;
  - after the pixel with cx == XSize and cy == YSize, go to DRAIN.
- A valid-tag shift register of depth RD_LATENCY tracks each oRdEn.
- On every cycle where the tag emerges:
  - oPixelCount increments;
  - oMatchCount increments if iRdData == latched colour.
  - This is active in both SCAN and DRAIN.
- DRAIN lasts exactly RD_LATENCY cycles, then goes to DONE.
- DONE:
  - oDone = 1 for one cycle;
  - oAllMatch is updated;
  - go to IDLE.
- Counts and oAllMatch hold until the next accepted iStart.
- iStart outside IDLE is ignored. This includes iStart in the DONE cycle.
- Inputs other than iRdData may change freely after iStart is accepted; only the latched copies are used.
- Reset values: all outputs 0, state IDLE, tag pipe cleared.
- Reset mid-operation: abort immediately and discard pending tags.

## Timing
- Cycle 0: iStart sampled in IDLE.
- With N = (XSize+1)*(YSize+1), SCAN occupies cycles 1..N. oRdEn and oAddr for pixel k (raster index, 0-based) are valid in cycle k+1.
- Data for pixel k is sampled in cycle k+1+RD_LATENCY.
- DRAIN occupies cycles N+1..N+RD_LATENCY.
- oBusy is high in cycles 1..N+RD_LATENCY.
- oDone and the final counts and oAllMatch are valid in cycle N+RD_LATENCY+1.
- Earliest next accepted iStart is cycle N+RD_LATENCY+2. Total turnaround is fixed regardless of clipping.
- Maximum N is 256*128. The offset counters are 8 and 7 bits. Count outputs never exceed 19200.

## Test plan
- Box at (10,20), size (1,1), framebuffer model filled with 3'b100, target 3'b100, RD_LATENCY=1, iStart at cycle 0:
  - oAddr 3210, 3211, 3370, 3371 in cycles 1-4;
  - oDone at cycle 6 with counts 4/4 and oAllMatch=1.
- Single pixel (0,0), size (0,0), memory 3'b001, target 3'b010:
  - one read at address 0;
  - oDone at cycle 3 with oPixelCount=1, oMatchCount=0, oAllMatch=0.
- Clipping: (158,118), size (3,3):
  - exactly 4 reads, at addresses 19038, 19039, 19198, 19199;
  - oBusy for 17 cycles;
  - oDone at cycle 18 with oPixelCount=4.
- Mixed region (4x1 at (0,0), memory colours 7,7,0,7, target 7):
  - oMatchCount=3, oPixelCount=4, oAllMatch=0;
  - iStart pulsed at cycle 2 is ignored (single oDone).
- Reset asserted asynchronously at cycle 3 of a 3x3 scan:
  - all outputs 0 immediately, state IDLE;
  - a new start of a 2x1 box completes normally with correct counts.
- RD_LATENCY=3, two back-to-back 2x2 scans, started at cycle 0 and again at cycle 9:
  - oDone at cycles 8 and 17;
  - the second scan's counts reflect only the second box.

Source files
------------

// File: rtl/box_readback.sv
// Framebuffer region reader: scans a clipped rectangle in raster order, one read per
// pixel, and counts returned pixels that equal a target colour.
module box_readback #(
  parameter int X_SCREEN_PIXELS = 160,
  parameter int Y_SCREEN_PIXELS = 120,
  parameter int RD_LATENCY      = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [7:0]  iX,
  input  logic [6:0]  iY,
  input  logic [7:0]  iXSize,
  input  logic [6:0]  iYSize,
  input  logic [2:0]  iColour,
  output logic [14:0] oAddr,
  output logic        oRdEn,
  input  logic [2:0]  iRdData,
  output logic        oBusy,
  output logic        oDone,
  output logic [14:0] oPixelCount,
  output logic [14:0] oMatchCount,
  output logic        oAllMatch
);

  // state   | meaning
  // S_IDLE  | waiting for iStart
  // S_SCAN  | issuing one pixel read per cycle
  // S_DRAIN | waiting RD_LATENCY cycles for the last read data
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

  localparam logic [14:0] STRIDE = 15'(X_SCREEN_PIXELS);

  state_t state, state_nxt;

  logic [7:0]  x_r, xs_r, cx, src_x, src_xs, off_x;
  logic [6:0]  y_r, ys_r, cy, src_y, src_ys, off_y;
  logic [2:0]  col_r;
  logic        more;
  logic        issue, in_screen, row_end, last;
  logic [8:0]  px;
  logic [7:0]  py;
  logic        rd_en_r;
  logic [14:0] addr_r;
  logic [RD_LATENCY-1:0] tag;
  logic [14:0] pix_r, match_r, pix_nxt, match_nxt;
  logic        all_r;
  logic [1:0]  drain_cnt;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (iStart) state_nxt = S_SCAN;
      S_SCAN:  if (!more) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt == 2'd0) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    oBusy       = (state == S_SCAN) || (state == S_DRAIN);
    oDone       = (state == S_DONE);
    oRdEn       = rd_en_r;
    oAddr       = addr_r;
    oPixelCount = pix_r;
    oMatchCount = match_r;
    oAllMatch   = all_r;
  end

  // Pixel 0 is issued straight from the inputs on the accepting edge so its read
  // appears in the first SCAN cycle; later pixels come from the latched copies.
  always_comb begin
    src_x  = x_r;
    src_y  = y_r;
    src_xs = xs_r;
    src_ys = ys_r;
    off_x  = cx;
    off_y  = cy;
    issue  = 1'b0;
    if (state == S_IDLE && iStart) begin
      src_x  = iX;
      src_y  = iY;
      src_xs = iXSize;
      src_ys = iYSize;
      off_x  = '0;
      off_y  = '0;
      issue  = 1'b1;
    end else if (state == S_SCAN && more) begin
      issue = 1'b1;
    end
    px        = {1'b0, src_x} + {1'b0, off_x};
    py        = {1'b0, src_y} + {1'b0, off_y};
    in_screen = (px < 9'(X_SCREEN_PIXELS)) && (py < 8'(Y_SCREEN_PIXELS));
    row_end   = (off_x == src_xs);
    last      = row_end && (off_y == src_ys);
  end

  always_comb begin
    pix_nxt   = pix_r;
    match_nxt = match_r;
    if (tag[RD_LATENCY-1]) begin
      pix_nxt = pix_r + 15'd1;
      if (iRdData == col_r) match_nxt = match_r + 15'd1;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      x_r       <= '0;
      y_r       <= '0;
      xs_r      <= '0;
      ys_r      <= '0;
      col_r     <= '0;
      cx        <= '0;
      cy        <= '0;
      more      <= 1'b0;
      rd_en_r   <= 1'b0;
      addr_r    <= '0;
      tag       <= '0;
      pix_r     <= '0;
      match_r   <= '0;
      all_r     <= 1'b0;
      drain_cnt <= '0;
    end else begin
      tag[0] <= rd_en_r;
      for (int i = 1; i < RD_LATENCY; i++) tag[i] <= tag[i-1];

      if (state == S_IDLE && iStart) begin
        x_r     <= iX;
        y_r     <= iY;
        xs_r    <= iXSize;
        ys_r    <= iYSize;
        col_r   <= iColour;
        pix_r   <= '0;
        match_r <= '0;
        all_r   <= 1'b0;
      end else begin
        pix_r   <= pix_nxt;
        match_r <= match_nxt;
        if (state == S_DRAIN && drain_cnt == 2'd0)
          all_r <= (pix_nxt != 15'd0) && (match_nxt == pix_nxt);
      end

      if (issue) begin
        rd_en_r <= in_screen;
        if (in_screen) addr_r <= 15'(py) * STRIDE + 15'(px);
        cx   <= row_end ? 8'd0 : off_x + 8'd1;
        cy   <= row_end ? off_y + 7'd1 : off_y;
        more <= !last;
      end else begin
        rd_en_r <= 1'b0;
      end

      if (state == S_SCAN && !more)
        drain_cnt <= 2'(RD_LATENCY - 1);
      else if (state == S_DRAIN && drain_cnt != 2'd0)
        drain_cnt <= drain_cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_box_readback.sv
// Directed bench for box_readback: one instance at read latency 1, one at latency 3,
// both reading a shared framebuffer model.
module tb_box_readback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start;
  logic [7:0]  x, xs;
  logic [6:0]  y, ys;
  logic [2:0]  col, rdata;
  logic [14:0] addr, pix, match;
  logic        rd_en, busy, done, allm;

  logic        l3_start;
  logic [7:0]  l3_x, l3_xs;
  logic [6:0]  l3_y, l3_ys;
  logic [2:0]  l3_col, l3_rdata, l3_p1, l3_p2;
  logic [14:0] l3_addr, l3_pix, l3_match;
  logic        l3_rd_en, l3_busy, l3_done, l3_allm;

  logic [2:0] mem [0:32767];

  int n_vec = 0;
  int n_miss = 0;

  int rd_q[$];
  int busy_n, done_n, done_cyc, done_pix, done_match, done_allm;

  always #5 clk = ~clk;

  box_readback #(.RD_LATENCY(1)) u_dut (
    .iClock(clk), .iReset(rst), .iStart(start), .iX(x), .iY(y), .iXSize(xs), .iYSize(ys),
    .iColour(col), .oAddr(addr), .oRdEn(rd_en), .iRdData(rdata), .oBusy(busy),
    .oDone(done), .oPixelCount(pix), .oMatchCount(match), .oAllMatch(allm)
  );

  box_readback #(.RD_LATENCY(3)) u_dut_l3 (
    .iClock(clk), .iReset(rst), .iStart(l3_start), .iX(l3_x), .iY(l3_y), .iXSize(l3_xs),
    .iYSize(l3_ys), .iColour(l3_col), .oAddr(l3_addr), .oRdEn(l3_rd_en), .iRdData(l3_rdata),
    .oBusy(l3_busy), .oDone(l3_done), .oPixelCount(l3_pix), .oMatchCount(l3_match),
    .oAllMatch(l3_allm)
  );

  always @(posedge clk) begin
    rdata    <= mem[addr];
    l3_p1    <= mem[l3_addr];
    l3_p2    <= l3_p1;
    l3_rdata <= l3_p2;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reads(input string tag, input int exp[$]);
    chk({tag, "_nrd"}, rd_q.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s_a%0d", tag, i), (i < rd_q.size()) ? rd_q[i] : -1, exp[i]);
  endtask

  task automatic fill(input logic [2:0] c);
    for (int i = 0; i < 19200; i++) mem[i] = c;
  endtask

  // Starts a box in cycle 0 and records cycles 1..ncyc; inputs are scrambled after
  // acceptance so only latched copies can produce the right answer.
  task automatic run_box(input logic [7:0] bx, input logic [6:0] by, input logic [7:0] bxs,
                         input logic [6:0] bys, input logic [2:0] bc, input int stray,
                         input int ncyc);
    rd_q.delete();
    busy_n = 0; done_n = 0; done_cyc = -1;
    done_pix = -1; done_match = -1; done_allm = -1;
    @(negedge clk);
    x = bx; y = by; xs = bxs; ys = bys; col = bc; start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      start = (c == stray);
      x = 8'd3; y = 7'd5; xs = 8'd9; ys = 7'd9; col = ~bc;
      @(negedge clk);
      if (rd_en) rd_q.push_back(int'(addr));
      if (busy) busy_n++;
      if (done) begin
        done_n++; done_cyc = c;
        done_pix = int'(pix); done_match = int'(match); done_allm = int'(allm);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    start = 0; x = 0; y = 0; xs = 0; ys = 0; col = 0;
    l3_start = 0; l3_x = 0; l3_y = 0; l3_xs = 0; l3_ys = 0; l3_col = 0;
    fill(3'd0);
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_rden", rd_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pix", pix, 0);
    chk("rst_allm", allm, 0);
    #20 rst = 1'b0;

    fill(3'b100);
    run_box(8'd10, 7'd20, 8'd1, 7'd1, 3'b100, 0, 10);
    chk_reads("t1", '{3210, 3211, 3370, 3371});
    chk("t1_busy", busy_n, 5);
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_pix", done_pix, 4);
    chk("t1_match", done_match, 4);
    chk("t1_allm", done_allm, 1);
    chk("t1_hold_pix", pix, 4);

    fill(3'b001);
    run_box(8'd0, 7'd0, 8'd0, 7'd0, 3'b010, 0, 6);
    chk_reads("t2", '{0});
    chk("t2_done_cyc", done_cyc, 3);
    chk("t2_pix", done_pix, 1);
    chk("t2_match", done_match, 0);
    chk("t2_allm", done_allm, 0);

    fill(3'd2);
    run_box(8'd158, 7'd118, 8'd3, 7'd3, 3'd2, 0, 22);
    chk_reads("t3", '{19038, 19039, 19198, 19199});
    chk("t3_busy", busy_n, 17);
    chk("t3_done_cyc", done_cyc, 18);
    chk("t3_pix", done_pix, 4);
    chk("t3_allm", done_allm, 1);

    fill(3'd0);
    mem[0] = 3'd7; mem[1] = 3'd7; mem[2] = 3'd0; mem[3] = 3'd7;
    run_box(8'd0, 7'd0, 8'd3, 7'd0, 3'd7, 2, 12);
    chk("t4_match", done_match, 3);
    chk("t4_pix", done_pix, 4);
    chk("t4_allm", done_allm, 0);
    chk("t4_ndone", done_n, 1);
    chk("t4_done_cyc", done_cyc, 6);

    fill(3'd6);
    @(negedge clk);
    x = 0; y = 0; xs = 8'd2; ys = 7'd2; col = 3'd6; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_rden", rd_en, 0);
    chk("t5_addr", addr, 0);
    chk("t5_pix", pix, 0);
    chk("t5_match", match, 0);
    chk("t5_done", done, 0);
    @(negedge clk) rst = 1'b0;
    fill(3'd3);
    run_box(8'd1, 7'd1, 8'd1, 7'd0, 3'd3, 0, 8);
    chk_reads("t5b", '{161, 162});
    chk("t5b_done_cyc", done_cyc, 4);
    chk("t5b_pix", done_pix, 2);
    chk("t5b_match", done_match, 2);
    chk("t5b_allm", done_allm, 1);

    fill(3'd5);
    mem[806] = 3'd2;
    begin
      int dq[$];
      int pq[$];
      int mq[$];
      int aq[$];
      @(negedge clk);
      l3_x = 0; l3_y = 0; l3_xs = 8'd1; l3_ys = 7'd1; l3_col = 3'd5; l3_start = 1'b1;
      for (int c = 1; c <= 22; c++) begin
        @(posedge clk); #1;
        l3_start = (c == 9);
        if (c == 9) begin
          l3_x = 8'd5; l3_y = 7'd5; l3_xs = 8'd1; l3_ys = 7'd1; l3_col = 3'd5;
        end
        @(negedge clk);
        if (l3_done) begin
          dq.push_back(c); pq.push_back(int'(l3_pix));
          mq.push_back(int'(l3_match)); aq.push_back(int'(l3_allm));
        end
      end
      l3_start = 1'b0;
      chk("t6_ndone", dq.size(), 2);
      chk("t6_done1", (dq.size() > 0) ? dq[0] : -1, 8);
      chk("t6_pix1", (pq.size() > 0) ? pq[0] : -1, 4);
      chk("t6_allm1", (aq.size() > 0) ? aq[0] : -1, 1);
      chk("t6_done2", (dq.size() > 1) ? dq[1] : -1, 17);
      chk("t6_pix2", (pq.size() > 1) ? pq[1] : -1, 4);
      chk("t6_match2", (mq.size() > 1) ? mq[1] : -1, 3);
      chk("t6_allm2", (aq.size() > 1) ? aq[1] : -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
